bcd_operand_entry: RTL and testbench
====================================

# bcd_operand_entry

Consumes the single-cycle button pulses produced by the front-panel button synchronisers and turns them into two 3-digit BCD operands for the ALU. It keeps an editable working value with a selected digit and a blink flag for the display driver. After the second operand is committed it raises a one-cycle `operandsValid` strobe. It sits between the button synchronisers and the ALU/display datapath.

## Interface
- `BLINK_CYCLES`, default 60000000: clock cycles per blink half-period (0.5 s at 120 MHz); legal range 2 to 2^32-1.
- `clk`  in  1  system clock, 120 MHz, rising-edge.
- `resetPulse`  in  1  asynchronous, active-low reset.
- `incPulse`  in  1  increment selected digit; each high cycle is one event.
- `decPulse`  in  1  decrement selected digit; each high cycle is one event.
- `nextPulse`  in  1  move digit selection; each high cycle is one event.
- `enterPulse`  in  1  commit working value / advance state.
- `working`  out  12  BCD working value, `[11:8]` hundreds, `[7:4]` tens, `[3:0]` ones.
- `digitSel`  out  2  selected digit: 0 = ones, 1 = tens, 2 = hundreds; 3 is never output.
- `blinkOn`  out  1  display enable for the selected digit; toggles every `BLINK_CYCLES`.
- `entryState`  out  2  0 = ENTRY_A, 1 = ENTRY_B, 2 = READY; 3 is never output.
- `operandA`  out  12  committed operand A in BCD.
- `operandB`  out  12  committed operand B in BCD.
- `operandsValid`  out  1  one-cycle strobe when operand B is committed.

## Operation
- Reset (`resetPulse`=0, asynchronous) sets:
  - `working`=0x000, `digitSel`=0, `entryState`=ENTRY_A, `operandA`=`operandB`=0x000;
  - `operandsValid`=0, `blinkOn`=1, blink counter=0.
- At most one action per cycle. Priority is enter > next > inc > dec; lower-priority pulses in the same cycle are dropped.
- inc (ENTRY_A/ENTRY_B only): the selected nibble goes +1 modulo 10 (9 becomes 0). No carry into other digits.
- dec (ENTRY_A/ENTRY_B only): the selected nibble goes -1 modulo 10 (0 becomes 9). No borrow from other digits.
- next (ENTRY_A/ENTRY_B only): `digitSel` steps 0→1→2→0.
- enter, by state:
  - ENTRY_A: `operandA`←`working`; `working`←0; `digitSel`←0; go to ENTRY_B.
  - ENTRY_B: `operandB`←`working`; `operandsValid`=1 for exactly one cycle; `working`←0; `digitSel`←0; go to READY.
  - READY: `operandA`←0; `operandB`←0; go to ENTRY_A.
- In READY, inc, dec and next are ignored.
- Any non-ignored inc, dec, next or enter clears the blink counter and forces `blinkOn`=1, so an edited digit is always visible.
- Blink counter:
  - Otherwise it counts 0 to `BLINK_CYCLES`-1.
  - On reaching `BLINK_CYCLES`-1 it wraps to 0 and `blinkOn` toggles.
  - It runs in all three states.
- All nibbles hold 0–9 at all times; invalid BCD is unreachable.

## Timing
- All outputs are registered. An action sampled at rising edge N is visible after edge N; latency is 1 cycle.
- `operandsValid` is high for the single cycle after the committing edge and low thereafter.
- `entryState` and `operandB` update on the same edge that asserts `operandsValid`.
- A held-high input repeats its action every cycle. Upstream synchronisers guarantee single-cycle pulses; the block does no edge detection.
- Reset asserted mid-entry clears everything immediately, without waiting for a clock edge.
- Reset release takes effect at the first rising edge after `resetPulse` returns high; no pulses are accepted before that edge.
- Blink period is exactly 2×`BLINK_CYCLES` cycles when no actions occur.

## Test plan
- Reset, then 3 inc, next, 2 inc, next, 1 inc, enter → `operandA`=0x123, `working`=0x000, `entryState`=1, `digitSel`=0.
- From ENTRY_B: 1 dec on ones → `working`=0x009. Then 10 inc → `working`=0x009 (wrap). Then enter → `operandB`=0x009, `operandsValid` high exactly 1 cycle, `entryState`=2.
- In READY, pulse inc/dec/next → `working`, `digitSel` unchanged. Then enter → `entryState`=0 and `operandA`=`operandB`=0x000.
- Simultaneous pulses: enter+inc in the same cycle → only commit occurs. next+inc in the same cycle → only `digitSel` changes.
- Blink, with `BLINK_CYCLES`=4: idle → `blinkOn` toggles every 4 cycles. An inc mid-period → `blinkOn`=1 and the next toggle comes 4 cycles after the inc.
- Drive `resetPulse` low between clock edges during ENTRY_B with `working`=0x456 → all outputs take their reset values immediately. After release, `entryState`=0.

Source files
------------

// File: rtl/bcd_operand_entry.sv
// Front-panel operand entry: edits a 3-digit BCD working value from button pulses
// and commits it as operand A, then operand B, for the ALU. Also drives the digit blink.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ENTRY_A | editing the working value; enter commits it to operandA
// ENTRY_B | editing the working value; enter commits it to operandB
// READY   | both operands held; edits ignored, enter clears and restarts
module bcd_operand_entry #(
    parameter int unsigned BLINK_CYCLES = 60000000
) (
    input  logic        clk,
    input  logic        resetPulse,
    input  logic        incPulse,
    input  logic        decPulse,
    input  logic        nextPulse,
    input  logic        enterPulse,
    output logic [11:0] working,
    output logic [1:0]  digitSel,
    output logic        blinkOn,
    output logic [1:0]  entryState,
    output logic [11:0] operandA,
    output logic [11:0] operandB,
    output logic        operandsValid
);

    typedef enum logic [1:0] {
        ENTRY_A = 2'd0,
        ENTRY_B = 2'd1,
        READY   = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_ENTER,
        ACT_NEXT,
        ACT_INC,
        ACT_DEC
    } act_t;

    localparam logic [31:0] BLINK_LAST = 32'(BLINK_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    act_t        act;
    logic [3:0]  sel_nib;
    logic [3:0]  sel_nib_nxt;
    logic [11:0] working_edit;
    logic [31:0] blink_cnt;

    function automatic logic [3:0] bcd_step(input logic [3:0] d, input logic up);
        if (up)
            return (d == 4'd9) ? 4'd0 : d + 4'd1;
        else
            return (d == 4'd0) ? 4'd9 : d - 4'd1;
    endfunction

    always_ff @(posedge clk or negedge resetPulse) begin
        if (!resetPulse)
            state <= ENTRY_A;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (enterPulse) begin
            case (state)
                ENTRY_A: state_nxt = ENTRY_B;
                ENTRY_B: state_nxt = READY;
                default: state_nxt = ENTRY_A;
            endcase
        end
    end

    // One action per cycle: enter > next > inc > dec; edits are dead in READY.
    always_comb begin
        act = ACT_NONE;
        if (enterPulse)
            act = ACT_ENTER;
        else if (state != READY) begin
            if (nextPulse)
                act = ACT_NEXT;
            else if (incPulse)
                act = ACT_INC;
            else if (decPulse)
                act = ACT_DEC;
        end

        case (digitSel)
            2'd0:    sel_nib = working[3:0];
            2'd1:    sel_nib = working[7:4];
            default: sel_nib = working[11:8];
        endcase
        sel_nib_nxt = bcd_step(sel_nib, act == ACT_INC);

        working_edit = working;
        case (digitSel)
            2'd0:    working_edit[3:0]  = sel_nib_nxt;
            2'd1:    working_edit[7:4]  = sel_nib_nxt;
            default: working_edit[11:8] = sel_nib_nxt;
        endcase
    end

    always_ff @(posedge clk or negedge resetPulse) begin
        if (!resetPulse) begin
            working       <= 12'h000;
            digitSel      <= 2'd0;
            operandA      <= 12'h000;
            operandB      <= 12'h000;
            operandsValid <= 1'b0;
            blinkOn       <= 1'b1;
            blink_cnt     <= 32'd0;
        end else begin
            operandsValid <= 1'b0;
            case (act)
                ACT_ENTER: begin
                    working  <= 12'h000;
                    digitSel <= 2'd0;
                    case (state)
                        ENTRY_A: operandA <= working;
                        ENTRY_B: begin
                            operandB      <= working;
                            operandsValid <= 1'b1;
                        end
                        default: begin
                            operandA <= 12'h000;
                            operandB <= 12'h000;
                        end
                    endcase
                end
                ACT_NEXT: digitSel <= (digitSel == 2'd2) ? 2'd0 : digitSel + 2'd1;
                ACT_INC, ACT_DEC: working <= working_edit;
                default: ;
            endcase

            // Any accepted action restarts the blink so the edited digit stays lit.
            if (act != ACT_NONE) begin
                blink_cnt <= 32'd0;
                blinkOn   <= 1'b1;
            end else if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= 32'd0;
                blinkOn   <= ~blinkOn;
            end else begin
                blink_cnt <= blink_cnt + 32'd1;
            end
        end
    end

    assign entryState = state;

endmodule

// File: tb/tb_bcd_operand_entry.sv
// Bench for bcd_operand_entry: digit-array model checked every cycle, plus
// literal expectations for the directed scenarios.
module tb_bcd_operand_entry;

    localparam int BC = 4;

    logic        clk = 1'b0;
    logic        resetPulse = 1'b1;
    logic        incPulse = 1'b0;
    logic        decPulse = 1'b0;
    logic        nextPulse = 1'b0;
    logic        enterPulse = 1'b0;
    logic [11:0] working;
    logic [1:0]  digitSel;
    logic        blinkOn;
    logic [1:0]  entryState;
    logic [11:0] operandA;
    logic [11:0] operandB;
    logic        operandsValid;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    bcd_operand_entry #(.BLINK_CYCLES(BC)) dut (
        .clk(clk),
        .resetPulse(resetPulse),
        .incPulse(incPulse),
        .decPulse(decPulse),
        .nextPulse(nextPulse),
        .enterPulse(enterPulse),
        .working(working),
        .digitSel(digitSel),
        .blinkOn(blinkOn),
        .entryState(entryState),
        .operandA(operandA),
        .operandB(operandB),
        .operandsValid(operandsValid)
    );

    always #5 clk = ~clk;

    // Model: digits as plain integers, blink derived from cycles since last action.
    int          m_dig[3] = '{0, 0, 0};
    int          m_sel = 0;
    int          m_state = 0;
    logic [11:0] m_opa = 12'h000;
    logic [11:0] m_opb = 12'h000;
    logic        m_valid = 1'b0;
    int          m_since = 0;

    function automatic logic [11:0] bcd3(input int h, input int t, input int o);
        return {4'(h), 4'(t), 4'(o)};
    endfunction

    always @(posedge clk or negedge resetPulse) begin
        if (!resetPulse) begin
            m_dig   <= '{0, 0, 0};
            m_sel   <= 0;
            m_state <= 0;
            m_opa   <= 12'h000;
            m_opb   <= 12'h000;
            m_valid <= 1'b0;
            m_since <= 0;
        end else begin
            m_valid <= 1'b0;
            if (enterPulse) begin
                m_since <= 0;
                m_dig   <= '{0, 0, 0};
                m_sel   <= 0;
                if (m_state == 0) begin
                    m_opa   <= bcd3(m_dig[2], m_dig[1], m_dig[0]);
                    m_state <= 1;
                end else if (m_state == 1) begin
                    m_opb   <= bcd3(m_dig[2], m_dig[1], m_dig[0]);
                    m_valid <= 1'b1;
                    m_state <= 2;
                end else begin
                    m_opa   <= 12'h000;
                    m_opb   <= 12'h000;
                    m_state <= 0;
                end
            end else if (m_state != 2 && (nextPulse || incPulse || decPulse)) begin
                m_since <= 0;
                if (nextPulse)
                    m_sel <= (m_sel + 1) % 3;
                else if (incPulse)
                    m_dig[m_sel] <= (m_dig[m_sel] + 1) % 10;
                else
                    m_dig[m_sel] <= (m_dig[m_sel] + 9) % 10;
            end else begin
                m_since <= m_since + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_working", 32'(working), 32'(bcd3(m_dig[2], m_dig[1], m_dig[0])));
            check("m_digitSel", 32'(digitSel), 32'(m_sel));
            check("m_entryState", 32'(entryState), 32'(m_state));
            check("m_operandA", 32'(operandA), 32'(m_opa));
            check("m_operandB", 32'(operandB), 32'(m_opb));
            check("m_valid", 32'(operandsValid), 32'(m_valid));
            check("m_blinkOn", 32'(blinkOn), 32'(((m_since / BC) % 2) == 0));
        end
    end

    task automatic step(input logic e, input logic n, input logic i, input logic d);
        @(posedge clk);
        #2;
        enterPulse = e;
        nextPulse  = n;
        incPulse   = i;
        decPulse   = d;
    endtask

    task automatic settle();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic check_reset_values();
        check("rst_working", 32'(working), 32'h000);
        check("rst_digitSel", 32'(digitSel), 32'd0);
        check("rst_entryState", 32'(entryState), 32'd0);
        check("rst_operandA", 32'(operandA), 32'h000);
        check("rst_operandB", 32'(operandB), 32'h000);
        check("rst_valid", 32'(operandsValid), 32'd0);
        check("rst_blinkOn", 32'(blinkOn), 32'd1);
    endtask

    // Reset asserted and released between clock edges.
    task automatic do_reset();
        @(posedge clk);
        #3;
        resetPulse = 1'b0;
        #1;
        check_reset_values();
        @(posedge clk);
        #3;
        resetPulse = 1'b1;
    endtask

    logic exp_idle[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic exp_after[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        #1;
        resetPulse = 1'b0;
        cmp_en = 1'b1;
        #2;
        check_reset_values();
        #19;
        resetPulse = 1'b1;

        // Idle blink: toggles every BC cycles from reset release.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("blink_idle", 32'(blinkOn), 32'(exp_idle[k]));
        end
        repeat (4) @(negedge clk);
        check("blink_low_before_inc", 32'(blinkOn), 32'd0);
        incPulse = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            incPulse = 1'b0;
            check("blink_after_inc", 32'(blinkOn), 32'(exp_after[k]));
        end
        check("inc_working", 32'(working), 32'h001);

        do_reset();

        // Enter operand A = 123.
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        check("a_operandA", 32'(operandA), 32'h123);
        check("a_working", 32'(working), 32'h000);
        check("a_state", 32'(entryState), 32'd1);
        check("a_digitSel", 32'(digitSel), 32'd0);

        // Operand B: dec wraps 0->9, ten incs wrap back to 9.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        check("b_dec_wrap", 32'(working), 32'h009);
        repeat (10) step(1'b0, 1'b0, 1'b1, 1'b0);
        settle();
        check("b_inc_wrap", 32'(working), 32'h009);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        check("b_valid_high", 32'(operandsValid), 32'd1);
        check("b_operandB", 32'(operandB), 32'h009);
        check("b_state", 32'(entryState), 32'd2);
        @(negedge clk);
        check("b_valid_low", 32'(operandsValid), 32'd0);

        // READY ignores edits; enter clears and restarts.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        settle();
        check("ready_working", 32'(working), 32'h000);
        check("ready_digitSel", 32'(digitSel), 32'd0);
        check("ready_state", 32'(entryState), 32'd2);
        check("ready_operandA", 32'(operandA), 32'h123);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        check("restart_state", 32'(entryState), 32'd0);
        check("restart_operandA", 32'(operandA), 32'h000);
        check("restart_operandB", 32'(operandB), 32'h000);

        // Priority: enter beats inc, next beats inc.
        repeat (2) step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        settle();
        check("prio_enter_state", 32'(entryState), 32'd1);
        check("prio_enter_opA", 32'(operandA), 32'h002);
        check("prio_enter_working", 32'(working), 32'h000);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        settle();
        check("prio_next_sel", 32'(digitSel), 32'd1);
        check("prio_next_working", 32'(working), 32'h000);

        // Build 456 in ENTRY_B, then reset between edges.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (6) step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b0, 1'b1, 1'b0);
        settle();
        check("pre_rst_working", 32'(working), 32'h456);
        check("pre_rst_state", 32'(entryState), 32'd1);
        do_reset();
        settle();
        check("post_rst_state", 32'(entryState), 32'd0);
        check("post_rst_working", 32'(working), 32'h000);

        repeat (3) @(negedge clk);
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
